wptr_ctrl_gen: RTL and testbench
================================

# wptr_ctrl_gen

Parametrised write-side pointer controller for the asynchronous FIFO, the successor to the fixed 16-entry write pointer controller. It lives in the write clock domain, drives the FIFO memory write address, exports a registered Gray write pointer to the read domain, and derives full, almost-full, fill level and a sticky overflow flag from the read pointer.

## Interface
- ADDR_W, 4: memory address width; DEPTH = 2**ADDR_W; pointers are ADDR_W+1 bits.
- AF_THRESH, DEPTH-2: almost_full asserts when level >= AF_THRESH; legal range 1..DEPTH.
- w_clk  in  1  write-domain clock.
- w_reset  in  1  synchronous, active-high reset.
- w_en  in  1  write request; accepted only when full=0.
- r_ptr_in  in  ADDR_W+1  read pointer (see Configuration for encoding).
- ovf_clr  in  1  clears the sticky overflow flag.
- w_add  out  ADDR_W  memory write address = wbin[ADDR_W-1:0].
- w_add_gray_synch  out  ADDR_W+1  registered Gray write pointer, to read domain.
- full  out  1  registered full flag.
- almost_full  out  1  registered almost-full flag.
- level  out  ADDR_W+1  registered occupancy, 0..DEPTH.
- overflow  out  1  sticky: write requested while full.

## Operation
- Internal binary pointer wbin (ADDR_W+1 bits); w_inc = w_en & ~full.
- wbin_next = wbin + w_inc, modulo 2**(ADDR_W+1); wraps without comment.
- rbin = read pointer in binary after Configuration-dependent handling.
- level_next = wbin_next - rbin, modulo 2**(ADDR_W+1).
- full_next = (wbin_next[ADDR_W] != rbin[ADDR_W]) && (wbin_next[ADDR_W-1:0] == rbin[ADDR_W-1:0]).
- almost_full_next = (level_next >= AF_THRESH).
- Every clock: wbin, w_add_gray_synch = bin2gray(wbin_next), full, almost_full, level take their _next values.
- overflow: set when w_en & full; cleared when ovf_clr; set wins if both in the same cycle.
- While full, w_en holds all pointers; no data is overwritten.
- Read pointer advancing while a write is accepted: both used in the same next-state computation; full may deassert and reassert in consecutive cycles.

## Timing
- Reset (w_reset=1 at a w_clk edge): wbin=0, w_add=0, w_add_gray_synch=0, full=0, almost_full=0, level=0, overflow=0; synchronizer flops (if present) = 0. Reset has priority over w_en and ovf_clr.
- Reset mid-operation discards the write pointer; the external read domain must be reset consistently (outside this block).
- Write latency: w_en sampled at edge N -> w_add and Gray pointer updated at edge N.
- Flags reflect the current-cycle write and read pointer, visible after edge N; no combinational input-to-output paths.
- Gray output changes at most one bit per cycle.

## Configuration
- WPTR_RSYNC_EN defined: r_ptr_in is the raw Gray read pointer from the read domain; it passes through a 2-flop synchronizer clocked by w_clk and gray2bin before use; flag response to read movement lags by 2 cycles.
- WPTR_RSYNC_EN undefined: r_ptr_in is already-synchronized binary; it is used directly with no added latency.

## Structure
- Shared package fifo_pkg: functions bin2gray/gray2bin parametrised by width, DEPTH derivation, pointer-width constant.
- One sub-module: ptr_sync2 (2-flop multi-bit synchronizer, synchronous active-high reset), instantiated only under WPTR_RSYNC_EN.

## Test plan
- ADDR_W=4, r_ptr_in=0, reset then w_en=1 for 20 cycles -> w_add counts 0..15, full=1 after 16th write, wbin stops at 16, level=16, overflow=1 from first blocked write.
- Reset, r_ptr_in=5 (binary, macro off), w_en=1 continuously -> wbin stops at 21, w_add=5, full=1, level=16.
- AF_THRESH=14: write from empty -> almost_full rises when level reaches 14, full at 16; advance r_ptr_in by 3 -> full=0, almost_full=0 next cycle at level 13.
- Wrap: r_ptr_in tracks writes lagging by 2 for 40 cycles -> wbin wraps 31->0, w_add_gray_synch changes one bit per step, full never asserts.
- overflow set, then ovf_clr=1 with w_en=1 & full=1 same cycle -> overflow stays 1; ovf_clr alone -> 0.
- w_reset=1 asserted while full and w_en=1 -> all outputs 0 next edge; with WPTR_RSYNC_EN, Gray read pointer step seen on flags exactly 2 cycles later.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared FIFO pointer helpers: Gray/binary conversion and pointer geometry.
// The conversions work on a 32-bit container; narrower pointers are zero-extended in and cast out.
package fifo_pkg;

  localparam int unsigned MaxPtrW = 32;

  function automatic int unsigned ptr_width(input int unsigned addr_w);
    return addr_w + 1;
  endfunction

  function automatic int unsigned depth_of(input int unsigned addr_w);
    return 32'd1 << addr_w;
  endfunction

  function automatic logic [MaxPtrW-1:0] bin2gray(input logic [MaxPtrW-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Zero-extended upper bits stay zero, so this is exact for any narrower width.
  function automatic logic [MaxPtrW-1:0] gray2bin(input logic [MaxPtrW-1:0] g);
    logic [MaxPtrW-1:0] b;
    b[MaxPtrW-1] = g[MaxPtrW-1];
    for (int i = MaxPtrW - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/ptr_sync2.sv
// Two-flop multi-bit synchronizer with synchronous active-high reset.
module ptr_sync2 #(
  parameter int unsigned Width = 5
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [Width-1:0] i_d,
  output logic [Width-1:0] o_q
);

  logic [Width-1:0] r_meta;
  logic [Width-1:0] r_sync;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/wptr_ctrl_gen.sv
// Write-side pointer controller for the async FIFO: address, Gray pointer, full/almost-full/level.
// Define WPTR_RSYNC_EN to take a raw Gray read pointer through an internal 2-flop synchronizer.
import fifo_pkg::*;

module wptr_ctrl_gen #(
  parameter int unsigned ADDR_W    = 4,
  parameter int unsigned AF_THRESH = depth_of(ADDR_W) - 2
) (
  input  logic              w_clk,
  input  logic              w_reset,
  input  logic              w_en,
  input  logic [ADDR_W:0]   r_ptr_in,
  input  logic              ovf_clr,
  output logic [ADDR_W-1:0] w_add,
  output logic [ADDR_W:0]   w_add_gray_synch,
  output logic              full,
  output logic              almost_full,
  output logic [ADDR_W:0]   level,
  output logic              overflow
);

  localparam int unsigned PtrW = ptr_width(ADDR_W);

  logic [PtrW-1:0] r_wbin;
  logic [PtrW-1:0] r_gray;
  logic [PtrW-1:0] r_level;
  logic            r_full;
  logic            r_af;
  logic            r_ovf;

  logic            w_inc;
  logic [PtrW-1:0] w_rbin;
  logic [PtrW-1:0] w_wbin_next;
  logic [PtrW-1:0] w_level_next;
  logic [PtrW-1:0] w_gray_next;
  logic            w_full_next;
  logic            w_af_next;

`ifdef WPTR_RSYNC_EN
  logic [PtrW-1:0] w_rgray_sync;

  ptr_sync2 #(
    .Width (PtrW)
  ) u_rsync (
    .i_clk   (w_clk),
    .i_reset (w_reset),
    .i_d     (r_ptr_in),
    .o_q     (w_rgray_sync)
  );

  assign w_rbin = PtrW'(gray2bin(MaxPtrW'(w_rgray_sync)));
`else
  assign w_rbin = r_ptr_in;
`endif

  // Full is judged on the post-write pointer so the flag never lags an accepted write.
  assign w_inc        = w_en & ~r_full;
  assign w_wbin_next  = r_wbin + PtrW'(w_inc);
  assign w_level_next = w_wbin_next - w_rbin;
  assign w_full_next  = (w_wbin_next[ADDR_W] != w_rbin[ADDR_W]) &&
                        (w_wbin_next[ADDR_W-1:0] == w_rbin[ADDR_W-1:0]);
  assign w_af_next    = MaxPtrW'(w_level_next) >= AF_THRESH;
  assign w_gray_next  = PtrW'(bin2gray(MaxPtrW'(w_wbin_next)));

  always_ff @(posedge w_clk) begin
    if (w_reset) begin
      r_wbin  <= '0;
      r_gray  <= '0;
      r_level <= '0;
      r_full  <= 1'b0;
      r_af    <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_wbin  <= w_wbin_next;
      r_gray  <= w_gray_next;
      r_level <= w_level_next;
      r_full  <= w_full_next;
      r_af    <= w_af_next;
      r_ovf   <= (w_en & r_full) | (r_ovf & ~ovf_clr);
    end
  end

  assign w_add            = r_wbin[ADDR_W-1:0];
  assign w_add_gray_synch = r_gray;
  assign full             = r_full;
  assign almost_full      = r_af;
  assign level            = r_level;
  assign overflow         = r_ovf;

endmodule

// File: tb/tb_wptr_ctrl_gen.sv
// Self-checking bench for wptr_ctrl_gen: reference model feeds a scoreboard, plus directed checks.
module tb_wptr_ctrl_gen;

  localparam int unsigned AW = 4;
  localparam int unsigned PW = AW + 1;
  localparam int unsigned AF = 14;

  logic          clk = 1'b0;
  logic          w_reset, w_en, ovf_clr;
  logic [PW-1:0] r_ptr_in;
  logic [AW-1:0] w_add;
  logic [PW-1:0] w_add_gray_synch, level;
  logic          full, almost_full, overflow;

  always #5 clk = ~clk;

  wptr_ctrl_gen #(
    .ADDR_W    (AW),
    .AF_THRESH (AF)
  ) dut (
    .w_clk            (clk),
    .w_reset          (w_reset),
    .w_en             (w_en),
    .r_ptr_in         (r_ptr_in),
    .ovf_clr          (ovf_clr),
    .w_add            (w_add),
    .w_add_gray_synch (w_add_gray_synch),
    .full             (full),
    .almost_full      (almost_full),
    .level            (level),
    .overflow         (overflow)
  );

  typedef struct packed {
    logic [AW-1:0] wadd;
    logic [PW-1:0] gray;
    logic          full;
    logic          af;
    logic [PW-1:0] level;
    logic          ovf;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  logic [PW-1:0] m_wbin, m_level, m_s1, m_s2;
  logic          m_full, m_af, m_ovf;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [PW-1:0] enc(input logic [PW-1:0] b);
`ifdef WPTR_RSYNC_EN
    return b ^ (b >> 1);
`else
    return b;
`endif
  endfunction

  function automatic logic [PW-1:0] g2b(input logic [PW-1:0] g);
    logic [PW-1:0] b;
    b[PW-1] = g[PW-1];
    for (int i = PW - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  // One clock: drive, advance the model, push expectation, then pop and compare after the edge.
  task automatic step(input logic rst, input logic en, input logic clr, input logic [PW-1:0] rp);
    logic [PW-1:0] wn, rb;
    logic [PW-1:0] prev_gray;
    exp_t e, o;
    w_reset  = rst;
    w_en     = en;
    ovf_clr  = clr;
    r_ptr_in = rp;
    prev_gray = w_add_gray_synch;
    if (rst) begin
      m_wbin = '0; m_level = '0; m_s1 = '0; m_s2 = '0;
      m_full = 1'b0; m_af = 1'b0; m_ovf = 1'b0;
    end else begin
      wn = m_wbin + ((en && !m_full) ? PW'(1) : PW'(0));
`ifdef WPTR_RSYNC_EN
      rb = g2b(m_s2);
`else
      rb = rp;
`endif
      m_ovf   = (en && m_full) || (m_ovf && !clr);
      m_level = wn - rb;
      m_full  = (wn[PW-1] != rb[PW-1]) && (wn[AW-1:0] == rb[AW-1:0]);
      m_af    = 32'(m_level) >= AF;
      m_wbin  = wn;
      m_s2    = m_s1;
      m_s1    = rp;
    end
    e.wadd  = m_wbin[AW-1:0];
    e.gray  = m_wbin ^ (m_wbin >> 1);
    e.full  = m_full;
    e.af    = m_af;
    e.level = m_level;
    e.ovf   = m_ovf;
    sb_q.push_back(e);
    @(posedge clk);
    @(negedge clk);
    o = sb_q.pop_front();
    check_eq("w_add", 32'(w_add), 32'(o.wadd));
    check_eq("gray", 32'(w_add_gray_synch), 32'(o.gray));
    check_eq("full", 32'(full), 32'(o.full));
    check_eq("almost_full", 32'(almost_full), 32'(o.af));
    check_eq("level", 32'(level), 32'(o.level));
    check_eq("overflow", 32'(overflow), 32'(o.ovf));
    if (!rst && !$isunknown(prev_gray))
      check_eq("gray_1bit", 32'($countones(prev_gray ^ w_add_gray_synch) <= 1), 32'd1);
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, 1'b0, '0);
    step(1'b1, 1'b0, 1'b0, '0);
  endtask

  initial begin
    int cnt;
    w_reset = 1'b1; w_en = 1'b0; ovf_clr = 1'b0; r_ptr_in = '0;

    do_reset();
    check_eq("rst_level", 32'(level), 32'd0);
    check_eq("rst_full", 32'(full), 32'd0);

    // Fill from empty with the reader stalled at 0; extra writes are blocked.
    for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 1'b0, enc(5'd0));
    check_eq("fill_full", 32'(full), 32'd1);
    check_eq("fill_level", 32'(level), 32'd16);
    check_eq("fill_wadd", 32'(w_add), 32'd0);
    check_eq("fill_ovf", 32'(overflow), 32'd1);

    // Reader parked at 5: writer stops at 21.
    do_reset();
    for (int i = 0; i < 24; i++) step(1'b0, 1'b1, 1'b0, enc(5'd5));
    check_eq("r5_wadd", 32'(w_add), 32'd5);
    check_eq("r5_full", 32'(full), 32'd1);
    check_eq("r5_level", 32'(level), 32'd16);

    // Almost-full threshold crossing and release by read advance.
    do_reset();
    for (int i = 0; i < 13; i++) step(1'b0, 1'b1, 1'b0, enc(5'd0));
    check_eq("af_below", 32'(almost_full), 32'd0);
    step(1'b0, 1'b1, 1'b0, enc(5'd0));
    check_eq("af_at14", 32'(almost_full), 32'd1);
    check_eq("af_nofull", 32'(full), 32'd0);
    step(1'b0, 1'b1, 1'b0, enc(5'd0));
    step(1'b0, 1'b1, 1'b0, enc(5'd0));
    check_eq("af_full16", 32'(full), 32'd1);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, enc(5'd3));
    check_eq("rel_full", 32'(full), 32'd0);
    check_eq("rel_af", 32'(almost_full), 32'd0);
    check_eq("rel_level", 32'(level), 32'd13);

    // Overflow: set wins over clear, clear alone drops it.
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, enc(5'd3));
    check_eq("ovf_pre", 32'(overflow), 32'd0);
    step(1'b0, 1'b1, 1'b0, enc(5'd3));
    check_eq("ovf_set", 32'(overflow), 32'd1);
    step(1'b0, 1'b1, 1'b1, enc(5'd3));
    check_eq("ovf_setwins", 32'(overflow), 32'd1);
    step(1'b0, 1'b0, 1'b1, enc(5'd3));
    check_eq("ovf_clr", 32'(overflow), 32'd0);

    // Wrap: reader trails by two writes.
    do_reset();
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      step(1'b0, 1'b1, 1'b0, enc(PW'(cnt >= 2 ? cnt - 2 : 0)));
      cnt++;
      check_eq("wrap_nofull", 32'(full), 32'd0);
    end
    check_eq("wrap_wadd", 32'(w_add), 32'd8);
    check_eq("wrap_gray", 32'(w_add_gray_synch), 32'd12);

    // Reset while full with a write pending.
    do_reset();
    for (int i = 0; i < 17; i++) step(1'b0, 1'b1, 1'b0, enc(5'd0));
    step(1'b1, 1'b1, 1'b1, enc(5'd0));
    check_eq("rstfull_full", 32'(full), 32'd0);
    check_eq("rstfull_gray", 32'(w_add_gray_synch), 32'd0);
    check_eq("rstfull_level", 32'(level), 32'd0);
    check_eq("rstfull_ovf", 32'(overflow), 32'd0);

    // Read-pointer latency to the flags.
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, enc(5'd0));
    step(1'b0, 1'b0, 1'b0, enc(5'd2));
`ifdef WPTR_RSYNC_EN
    check_eq("lat_e1", 32'(level), 32'd4);
    step(1'b0, 1'b0, 1'b0, enc(5'd2));
    check_eq("lat_e2", 32'(level), 32'd4);
    step(1'b0, 1'b0, 1'b0, enc(5'd2));
    check_eq("lat_e3", 32'(level), 32'd2);
`else
    check_eq("lat_e1", 32'(level), 32'd2);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
